// File: rtl/step_motor_driver_mc.sv
// step_motor_driver_mc: Avalon-MM driver for CHANNELS bipolar steppers with
// per-channel step timer, full/half-step sequencing and PWM chopping.
module step_motor_driver_mc #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 4
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset,
    input  logic [ADDR_W-1:0]   avs_ctrl_address,
    input  logic [31:0]         avs_ctrl_writedata,
    input  logic [3:0]          avs_ctrl_byteenable,
    input  logic                avs_ctrl_write,
    input  logic                avs_ctrl_read,
    output logic [31:0]         avs_ctrl_readdata,
    output logic                avs_ctrl_waitrequest,
    output logic [CHANNELS-1:0] AX,
    output logic [CHANNELS-1:0] AY,
    output logic [CHANNELS-1:0] BX,
    output logic [CHANNELS-1:0] BY,
    output logic [CHANNELS-1:0] AE,
    output logic [CHANNELS-1:0] BE
);

    localparam int CH_W = ADDR_W - 3;

    localparam logic [2:0] R_FREQ   = 3'd0;
    localparam logic [2:0] R_WIDTHA = 3'd1;
    localparam logic [2:0] R_WIDTHB = 3'd2;
    localparam logic [2:0] R_PERIOD = 3'd3;
    localparam logic [2:0] R_COUNT  = 3'd4;
    localparam logic [2:0] R_CTRL   = 3'd5;
    localparam logic [2:0] R_STATUS = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_e;

    logic [31:0] pwm_freq  [CHANNELS];
    logic [31:0] width_a   [CHANNELS];
    logic [31:0] width_b   [CHANNELS];
    logic [31:0] period    [CHANNELS];
    logic [31:0] remaining [CHANNELS];
    logic [31:0] timer     [CHANNELS];
    logic [31:0] acc       [CHANNELS];
    logic [3:0]  ctrl      [CHANNELS];
    logic [2:0]  phase     [CHANNELS];
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] pwm_a;
    logic [CHANNELS-1:0] pwm_b;

    seq_e        state    [CHANNELS];
    logic [31:0] per_eff  [CHANNELS];
    logic [2:0]  stride   [CHANNELS];
    logic [2:0]  idx_next [CHANNELS];
    logic [3:0]  pat      [CHANNELS];
    logic [CHANNELS-1:0] fire;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] cnt_wr;
    logic [CHANNELS-1:0] done_set;
    logic [CHANNELS-1:0] done_clr;

    logic [2:0]      reg_sel;
    logic [CH_W-1:0] ch_sel;
    logic [31:0]     be_mask;
    logic [31:0]     rd_val;

    assign reg_sel = avs_ctrl_address[2:0];
    assign ch_sel  = avs_ctrl_address[ADDR_W-1:3];
    assign be_mask = {{8{avs_ctrl_byteenable[3]}},
                      {8{avs_ctrl_byteenable[2]}},
                      {8{avs_ctrl_byteenable[1]}},
                      {8{avs_ctrl_byteenable[0]}}};

    assign avs_ctrl_waitrequest = 1'b0;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [31:0] mask
    );
        merge = (old & ~mask) | (data & mask);
    endfunction

    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    coil_pattern = 4'b1000;
            3'd1:    coil_pattern = 4'b1010;
            3'd2:    coil_pattern = 4'b0010;
            3'd3:    coil_pattern = 4'b0110;
            3'd4:    coil_pattern = 4'b0100;
            3'd5:    coil_pattern = 4'b0101;
            3'd6:    coil_pattern = 4'b0001;
            default: coil_pattern = 4'b1001;
        endcase
    endfunction

    // Sequencer state is a pure function of enable/continuous/remaining.
    always_comb begin
        fire     = '0;
        wr_hit   = '0;
        cnt_wr   = '0;
        done_set = '0;
        done_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state[c] = IDLE;
            if (ctrl[c][0] && (ctrl[c][3] || remaining[c] != 32'd0))
                state[c] = RUN;
            per_eff[c] = (period[c] == 32'd0) ? 32'd1 : period[c];
            fire[c] = (state[c] == RUN) &&
                      (timer[c] >= per_eff[c] - 32'd1);
            stride[c] = ctrl[c][2] ? 3'd1 : 3'd2;
            idx_next[c] = ctrl[c][1] ? phase[c] + stride[c]
                                     : phase[c] - stride[c];
            wr_hit[c] = avs_ctrl_write && (ch_sel == CH_W'(c));
            cnt_wr[c] = wr_hit[c] && (reg_sel == R_COUNT);
            done_set[c] = fire[c] && !ctrl[c][3] &&
                          (remaining[c] == 32'd1) && !cnt_wr[c];
            done_clr[c] = wr_hit[c] && (reg_sel == R_STATUS) &&
                          avs_ctrl_byteenable[0] &&
                          avs_ctrl_writedata[1];
        end
    end

    always_comb begin
        rd_val = 32'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == CH_W'(c)) begin
                case (reg_sel)
                    R_FREQ:   rd_val = pwm_freq[c];
                    R_WIDTHA: rd_val = width_a[c];
                    R_WIDTHB: rd_val = width_b[c];
                    R_PERIOD: rd_val = period[c];
                    R_COUNT:  rd_val = remaining[c];
                    R_CTRL:   rd_val = {28'd0, ctrl[c]};
                    R_STATUS: rd_val = {27'd0, phase[c], done[c],
                                        state[c] == RUN};
                    default:  rd_val = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            avs_ctrl_readdata <= 32'd0;
            done  <= '0;
            pwm_a <= '0;
            pwm_b <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_freq[c]  <= 32'd0;
                width_a[c]   <= 32'd0;
                width_b[c]   <= 32'd0;
                period[c]    <= 32'd0;
                remaining[c] <= 32'd0;
                timer[c]     <= 32'd0;
                acc[c]       <= 32'd0;
                ctrl[c]      <= 4'd0;
                phase[c]     <= 3'd0;
            end
        end else begin
            if (avs_ctrl_read && !avs_ctrl_write)
                avs_ctrl_readdata <= rd_val;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]   <= acc[c] + pwm_freq[c];
                pwm_a[c] <= acc[c] < width_a[c];
                pwm_b[c] <= acc[c] < width_b[c];

                if (state[c] == IDLE) begin
                    timer[c] <= 32'd0;
                end else if (fire[c]) begin
                    timer[c] <= 32'd0;
                    phase[c] <= idx_next[c];
                end else begin
                    timer[c] <= timer[c] + 32'd1;
                end

                if (fire[c] && !ctrl[c][3])
                    remaining[c] <= remaining[c] - 32'd1;

                if (done_set[c])
                    done[c] <= 1'b1;
                else if (done_clr[c])
                    done[c] <= 1'b0;

                // Bus writes win over the decrement in the same cycle.
                if (wr_hit[c]) begin
                    case (reg_sel)
                        R_FREQ: pwm_freq[c] <= merge(pwm_freq[c],
                            avs_ctrl_writedata, be_mask);
                        R_WIDTHA: width_a[c] <= merge(width_a[c],
                            avs_ctrl_writedata, be_mask);
                        R_WIDTHB: width_b[c] <= merge(width_b[c],
                            avs_ctrl_writedata, be_mask);
                        R_PERIOD: period[c] <= merge(period[c],
                            avs_ctrl_writedata, be_mask);
                        R_COUNT: remaining[c] <= merge(remaining[c],
                            avs_ctrl_writedata, be_mask);
                        R_CTRL: if (avs_ctrl_byteenable[0])
                            ctrl[c] <= avs_ctrl_writedata[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        AX = '1;
        AY = '1;
        BX = '1;
        BY = '1;
        AE = '1;
        BE = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            pat[c] = coil_pattern(phase[c]);
            AX[c] = ~(pat[c][3] & pwm_a[c] & ctrl[c][0]);
            AY[c] = ~(pat[c][2] & pwm_a[c] & ctrl[c][0]);
            BX[c] = ~(pat[c][1] & pwm_b[c] & ctrl[c][0]);
            BY[c] = ~(pat[c][0] & pwm_b[c] & ctrl[c][0]);
            AE[c] = ~ctrl[c][0];
            BE[c] = ~ctrl[c][0];
        end
    end

endmodule

// File: tb/tb_step_motor_driver_mc.sv
// tb_step_motor_driver_mc: directed and random bus traffic on the stepper
// driver, compared every cycle with a behavioural model of its registers.
module tb_step_motor_driver_mc;

    localparam int CH = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          wr;
    logic          rd;
    logic [31:0]   rdata;
    logic          wait_req;
    logic [CH-1:0] ax, ay, bx, by, ae, bee;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_motor_driver_mc #(
        .CHANNELS(CH),
        .ADDR_W  (AW)
    ) dut (
        .csi_MCLK_clk        (clk),
        .rsi_MRST_reset      (rst),
        .avs_ctrl_address    (addr),
        .avs_ctrl_writedata  (wdata),
        .avs_ctrl_byteenable (be),
        .avs_ctrl_write      (wr),
        .avs_ctrl_read       (rd),
        .avs_ctrl_readdata   (rdata),
        .avs_ctrl_waitrequest(wait_req),
        .AX                  (ax),
        .AY                  (ay),
        .BX                  (bx),
        .BY                  (by),
        .AE                  (ae),
        .BE                  (bee)
    );

    // Model state
    logic [31:0] m_freq [CH];
    logic [31:0] m_wa   [CH];
    logic [31:0] m_wb   [CH];
    logic [31:0] m_per  [CH];
    logic [31:0] m_rem  [CH];
    logic [31:0] m_tmr  [CH];
    logic [31:0] m_acc  [CH];
    logic [3:0]  m_ctrl [CH];
    logic        m_done [CH];
    logic        m_pa   [CH];
    logic        m_pb   [CH];
    int          m_idx  [CH];
    logic [31:0] m_rd;

    function automatic logic [3:0] coil_pattern(int i);
        case (i)
            0: return 4'b1000;
            1: return 4'b1010;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0100;
            5: return 4'b0101;
            6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [31:0] reg_value(int ch, int r);
        logic busy;
        if (ch >= CH) return 32'd0;
        busy = m_ctrl[ch][0] && (m_ctrl[ch][3] || m_rem[ch] != 0);
        case (r)
            0: return m_freq[ch];
            1: return m_wa[ch];
            2: return m_wb[ch];
            3: return m_per[ch];
            4: return m_rem[ch];
            5: return {28'd0, m_ctrl[ch]};
            6: return {27'd0, 3'(m_idx[ch]), m_done[ch], busy};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [6*CH-1:0] exp_pins();
        logic [CH-1:0] e_ax, e_ay, e_bx, e_by, e_en;
        logic [3:0] p;
        for (int c = 0; c < CH; c++) begin
            p = coil_pattern(m_idx[c]);
            e_en[c] = m_ctrl[c][0];
            e_ax[c] = !(p[3] && m_pa[c] && e_en[c]);
            e_ay[c] = !(p[2] && m_pa[c] && e_en[c]);
            e_bx[c] = !(p[1] && m_pb[c] && e_en[c]);
            e_by[c] = !(p[0] && m_pb[c] && e_en[c]);
        end
        return {e_ax, e_ay, e_bx, e_by, ~e_en, ~e_en};
    endfunction

    task automatic model_step();
        int ch, r, stride;
        logic [31:0] mask, old_rem;
        longint per;
        logic running, hit, set_now;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_freq[c] = 0; m_wa[c] = 0; m_wb[c] = 0;
                m_per[c] = 0;  m_rem[c] = 0; m_tmr[c] = 0;
                m_acc[c] = 0;  m_ctrl[c] = 0; m_done[c] = 0;
                m_pa[c] = 0;   m_pb[c] = 0;  m_idx[c] = 0;
            end
            m_rd = 0;
            return;
        end
        ch = int'(addr) / 8;
        r  = int'(addr) % 8;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (rd && !wr) m_rd = reg_value(ch, r);
        for (int c = 0; c < CH; c++) begin
            hit = wr && (ch == c);
            old_rem = m_rem[c];
            set_now = 0;
            running = m_ctrl[c][0] && (m_ctrl[c][3] || m_rem[c] != 0);
            per = (m_per[c] == 0) ? 1 : longint'(m_per[c]);
            stride = m_ctrl[c][2] ? 1 : 2;
            if (running && longint'(m_tmr[c]) + 1 >= per) begin
                if (m_ctrl[c][1]) m_idx[c] = (m_idx[c] + stride) % 8;
                else m_idx[c] = (m_idx[c] + 8 - stride) % 8;
                m_tmr[c] = 0;
                if (!m_ctrl[c][3] && !(hit && r == 4)) begin
                    m_rem[c] = m_rem[c] - 1;
                    if (m_rem[c] == 0) begin
                        m_done[c] = 1;
                        set_now = 1;
                    end
                end
            end else begin
                m_tmr[c] = running ? m_tmr[c] + 1 : 0;
            end
            m_pa[c] = m_acc[c] < m_wa[c];
            m_pb[c] = m_acc[c] < m_wb[c];
            m_acc[c] = m_acc[c] + m_freq[c];
            if (hit) begin
                case (r)
                    0: m_freq[c] = (m_freq[c] & ~mask) | (wdata & mask);
                    1: m_wa[c] = (m_wa[c] & ~mask) | (wdata & mask);
                    2: m_wb[c] = (m_wb[c] & ~mask) | (wdata & mask);
                    3: m_per[c] = (m_per[c] & ~mask) | (wdata & mask);
                    4: m_rem[c] = (old_rem & ~mask) | (wdata & mask);
                    5: if (be[0]) m_ctrl[c] = wdata[3:0];
                    6: if (be[0] && wdata[1] && !set_now) m_done[c] = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("readdata", rdata, m_rd);
        check("pins", 32'({ax, ay, bx, by, ae, bee}), 32'(exp_pins()));
    endtask

    task automatic idle_bus();
        wr = 0; rd = 0; be = 4'h0; wdata = 0; addr = '0;
    endtask

    task automatic bus_wr(int ch, int r, logic [31:0] d,
                          logic [3:0] b = 4'hF);
        addr = AW'(ch * 8 + r);
        wdata = d; be = b; wr = 1; rd = 0;
        cycle();
        idle_bus();
    endtask

    task automatic bus_rd(int ch, int r, output logic [31:0] d);
        addr = AW'(ch * 8 + r);
        rd = 1; wr = 0;
        cycle();
        idle_bus();
        d = rdata;
    endtask

    initial begin
        logic [31:0] d;
        int zeros, op, r;
        int exp_idx [6] = '{0, 6, 4, 2, 0, 6};

        idle_bus();
        rst = 1;
        cycle();
        rst = 0;
        check("reset_pins", 32'({ax, ay, bx, by, ae, bee}), 32'hFFF);
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 8; k++) begin
                bus_rd(c, k, d);
                check("reset_reg", d, 32'd0);
            end

        // Ch0: half-step forward, three steps of period 4
        bus_wr(0, 3, 4);
        bus_wr(0, 4, 3);
        bus_wr(0, 5, 32'h7);
        repeat (4) cycle();
        bus_rd(0, 6, d);
        check("ch0_step1", d, 32'd5);
        repeat (3) cycle();
        bus_rd(0, 6, d);
        check("ch0_step2", d, 32'd9);
        repeat (3) cycle();
        bus_rd(0, 6, d);
        check("ch0_step3_done", d, 32'd14);
        bus_rd(0, 4, d);
        check("ch0_remaining", d, 32'd0);
        bus_wr(0, 6, 32'h2);
        bus_rd(0, 6, d);
        check("ch0_done_clr", d, 32'd12);

        // Ch1: full-step reverse, period 1
        bus_wr(1, 3, 1);
        bus_wr(1, 4, 5);
        bus_wr(1, 5, 32'h1);
        for (int k = 0; k < 6; k++) begin
            bus_rd(1, 6, d);
            check("ch1_rev_idx", 32'(d[4:2]), 32'(exp_idx[k]));
        end
        check("ch1_rev_end", 32'(d[1:0]), 32'd2);

        // Ch0: continuous, disable mid-run, re-enable
        bus_wr(0, 3, 2);
        bus_wr(0, 5, 32'hB);
        repeat (7) cycle();
        bus_wr(0, 5, 32'hA);
        bus_rd(0, 6, d);
        check("ch0_hold", d, 32'd12);
        check("ch0_ae_off", 32'(ae[0]), 32'd1);
        repeat (5) cycle();
        bus_rd(0, 6, d);
        check("ch0_hold2", d, 32'd12);
        bus_wr(0, 5, 32'hB);
        repeat (2) cycle();
        bus_rd(0, 6, d);
        check("ch0_resume", d, 32'd21);

        // Ch1: move to index 0, then PWM on coil A
        bus_wr(1, 5, 32'h3);
        bus_wr(1, 4, 1);
        bus_wr(1, 0, 32'h4000_0000);
        bus_wr(1, 1, 32'h8000_0000);
        cycle();
        zeros = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (ax[1] == 1'b0) zeros++;
            if (k == 3) check("pwm_zeros4", 32'(zeros), 32'd2);
        end
        check("pwm_zeros8", 32'(zeros), 32'd4);
        bus_wr(1, 1, 32'd0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("pwm_w0_ax", 32'(ax[1]), 32'd1);
        end

        // STEP_COUNT written on the step-event cycle
        bus_wr(1, 3, 3);
        bus_wr(1, 4, 10);
        repeat (2) cycle();
        bus_wr(1, 4, 20);
        bus_rd(1, 4, d);
        check("count_on_step", d, 32'd20);
        bus_rd(1, 6, d);
        check("count_on_step_idx", 32'(d[4:2]), 32'd2);

        // Byte-enable, invalid channel, reserved register
        bus_wr(1, 3, 32'h1234_5603);
        bus_wr(1, 3, 32'hAABB_CC07, 4'h1);
        bus_rd(1, 3, d);
        check("period_be", d, 32'h1234_5607);
        bus_wr(1, 3, 2);
        bus_wr(3, 3, 32'hDEAD);
        bus_rd(3, 3, d);
        check("ch3_ignored", d, 32'd0);
        bus_wr(0, 7, 32'hFFFF_FFFF);
        bus_rd(0, 7, d);
        check("reserved", d, 32'd0);

        // Reset while ch0 is running
        rst = 1;
        cycle();
        rst = 0;
        check("midrun_reset_pins",
              32'({ax, ay, bx, by, ae, bee}), 32'hFFF);
        bus_rd(0, 6, d);
        check("midrun_reset_st", d, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 9);
            rst = ($urandom_range(0, 299) == 0);
            addr = AW'($urandom_range(0, 31));
            r = int'(addr) % 8;
            case (r)
                3: wdata = $urandom_range(0, 4);
                4: wdata = $urandom_range(0, 6);
                5: wdata = 32'($urandom_range(0, 15));
                default: wdata = $urandom;
            endcase
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wr = (op >= 4 && op <= 6) || op == 9;
            rd = op >= 7;
            cycle();
        end
        idle_bus();
        rst = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
